// File: rtl/uart_io_ctrl_if.sv
// uart_io_ctrl_if
//   CPU data-bus side of the UART I/O controller.
//   master : the CPU (drives addr/w_data/w_en/r_en, sees r_data/hit)
//   slave  : uart_io_ctrl (decodes the access, returns r_data/hit)
//   addr    [7:0]  data address
//   w_data  [7:0]  store data
//   w_en           store strobe
//   r_en           load strobe, qualifies RX FIFO pop
//   r_data  [7:0]  combinational read data
//   hit            addr matches one of the controller's registers
interface uart_io_ctrl_if;
    logic [7:0] addr;
    logic [7:0] w_data;
    logic       w_en;
    logic       r_en;
    logic [7:0] r_data;
    logic       hit;

    modport master (
        output addr, w_data, w_en, r_en,
        input  r_data, hit
    );

    modport slave (
        input  addr, w_data, w_en, r_en,
        output r_data, hit
    );
endinterface

// File: rtl/uart_io_ctrl.sv
// uart_io_ctrl
//   Memory-mapped UART sequencer: TX FIFO feeding a begin/busy handshake,
//   RX FIFO filled on rising edges of receive_flag, plus CTRL/STAT registers.
//   Optional macro UART_IRQ_EN adds a registered irq output.
// Ports:
//   clock, rst_n   clock (posedge) and asynchronous active-low reset
//   bus            CPU data-bus interface (slave modport)
//   tx_en, rx_en   CTRL bit0 / bit1
//   begin_flag     one-cycle start pulse to the UART transmitter
//   tx_data        byte being sent, held from the pulse until the byte is done
//   rx_data        received byte from the UART
//   busy_flag      UART transmitter busy
//   receive_flag   UART byte-received level
//   irq            (UART_IRQ_EN only) registered interrupt request
module uart_io_ctrl #(
    parameter int unsigned TX_DEPTH  = 4,
    parameter int unsigned RX_DEPTH  = 4,
    parameter logic [7:0]  ADDR_DATA = 8'd253,
    parameter logic [7:0]  ADDR_STAT = 8'd254,
    parameter logic [7:0]  ADDR_CTRL = 8'd255
) (
    input  logic           clock,
    input  logic           rst_n,
    uart_io_ctrl_if.slave  bus,
    output logic           tx_en,
    output logic           rx_en,
    output logic           begin_flag,
    output logic [7:0]     tx_data,
    input  logic [7:0]     rx_data,
    input  logic           busy_flag,
    input  logic           receive_flag
`ifdef UART_IRQ_EN
    ,
    output logic           irq
`endif
);

    localparam int unsigned TX_AW = $clog2(TX_DEPTH);
    localparam int unsigned RX_AW = $clog2(RX_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE
    } tx_state_t;

    tx_state_t state, state_nxt;

    logic [3:0]       ctrl;
    logic             overrun;
    logic             rf_q;

    logic [7:0]       tx_mem [TX_DEPTH];
    logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [TX_AW:0]   tx_count;
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [RX_AW:0]   rx_count;

    logic sel_data, sel_stat, sel_ctrl;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_load, tx_push;
    logic rx_edge, rx_pop, rx_push, ovr_set, ovr_clr;
    logic tx_busy;

    // ---------------- decode / FIFO control ----------------
    assign sel_data = (bus.addr == ADDR_DATA);
    assign sel_stat = (bus.addr == ADDR_STAT);
    assign sel_ctrl = (bus.addr == ADDR_CTRL);

    assign tx_en    = ctrl[0];
    assign rx_en    = ctrl[1];

    assign tx_empty = (tx_count == '0);
    assign tx_full  = (tx_count == (TX_AW + 1)'(TX_DEPTH));
    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == (RX_AW + 1)'(RX_DEPTH));

    // A full FIFO still accepts a push when the same edge pops.
    assign tx_push  = bus.w_en & sel_data & (~tx_full | tx_load);

    assign rx_edge  = receive_flag & ~rf_q & rx_en;
    assign rx_pop   = bus.r_en & sel_data & ~rx_empty;
    assign rx_push  = rx_edge & (~rx_full | rx_pop);
    assign ovr_set  = rx_edge & rx_full & ~rx_pop;
    assign ovr_clr  = bus.w_en & sel_stat & bus.w_data[3];

    assign tx_busy  = ~tx_empty | (state != S_IDLE);

    // ---------------- TX FSM: state register ----------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // ---------------- TX FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (tx_en && !tx_empty) state_nxt = S_START;
            S_START:     state_nxt = S_WAIT_ACK;
            S_WAIT_ACK:  if (busy_flag)  state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (!busy_flag) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // ---------------- TX FSM: outputs ----------------
    always_comb begin
        begin_flag = 1'b0;
        tx_load    = 1'b0;
        case (state)
            S_IDLE:  tx_load    = tx_en & ~tx_empty;
            S_START: begin_flag = 1'b1;
            default: ;
        endcase
    end

    // ---------------- TX FIFO ----------------
    always_ff @(posedge clock) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= bus.w_data;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
            tx_data   <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_load) begin
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
                tx_data   <= tx_mem[tx_rd_ptr];
            end
            case ({tx_push, tx_load})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    always_ff @(posedge clock) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_count  <= '0;
            rf_q      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // Tracks receive_flag even while rx_en=0, so enabling the
            // receiver with the flag already high does not fake an edge.
            rf_q <= receive_flag;
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: ;
            endcase
            // Set has priority over a simultaneous clear.
            if (ovr_set)      overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

    // ---------------- CTRL ----------------
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)                   ctrl <= '0;
        else if (bus.w_en && sel_ctrl) ctrl <= bus.w_data[3:0];
    end

    // ---------------- read mux ----------------
    always_comb begin
        bus.hit    = 1'b0;
        bus.r_data = '0;
        if (sel_data) begin
            bus.hit    = 1'b1;
            bus.r_data = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
        end else if (sel_stat) begin
            bus.hit    = 1'b1;
            bus.r_data = {4'b0, overrun, tx_full, ~rx_empty, tx_busy};
        end else if (sel_ctrl) begin
            bus.hit    = 1'b1;
            bus.r_data = {4'b0, ctrl};
        end
    end

`ifdef UART_IRQ_EN
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= (ctrl[2] & ~rx_empty)
                         | (ctrl[3] & tx_empty & (state == S_IDLE))
                         | overrun;
    end
`endif

endmodule

// File: doc/uart_io_ctrl.md
Name: uart_io_ctrl

Overview:
Memory-mapped controller that sits between the CPU data bus and the UART, and sequences the UART.
- Decodes the CPU's I/O addresses.
- Buffers outgoing bytes in a TX FIFO and issues a one-cycle begin_flag per byte.
- Captures received bytes into an RX FIFO.
- Exposes control and status registers.
The top level muxes r_data onto the CPU read path whenever hit=1.

Parameters:
- TX_DEPTH, 4, TX FIFO entries (power of 2, >=2)
- RX_DEPTH, 4, RX FIFO entries (power of 2, >=2)
- ADDR_DATA, 8'd253, write pushes TX FIFO; read returns RX head
- ADDR_STAT, 8'd254, status register
- ADDR_CTRL, 8'd255, control register

Ports:
- clock  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- addr  in  8  CPU data address (rs_data)
- w_data  in  8  CPU write data (rd_data)
- w_en  in  1  CPU store strobe
- r_en  in  1  CPU load strobe; qualifies RX pop
- r_data  out  8  combinational read data for addr
- hit  out  1  combinational; addr equals one of the three register addresses
- tx_en  out  1  UART transmitter enable (CTRL bit0)
- rx_en  out  1  UART receiver enable (CTRL bit1)
- begin_flag  out  1  one-cycle start pulse to UART
- tx_data  out  8  byte for UART; held stable from pulse until byte done
- rx_data  in  8  UART received byte
- busy_flag  in  1  UART transmitting
- receive_flag  in  1  UART byte-received level

Behaviour:
Reset (rst_n=0, async):
- CTRL=0, FIFOs empty, overrun=0, TX FSM in IDLE.
- begin_flag=0, tx_data=0, tx_en=0, rx_en=0.
- receive_flag edge register cleared.

Register writes (w_en=1):
- ADDR_DATA: push w_data to the TX FIFO. If the FIFO is full, drop the byte and leave state unchanged.
- ADDR_CTRL: CTRL <= w_data[3:0].
- ADDR_STAT: bit3=1 clears overrun; all other bits are ignored.

Register reads (combinational):
- ADDR_DATA returns the RX head, or 0 if the RX FIFO is empty. r_en=1 with a non-empty FIFO pops on the clock edge.
- ADDR_STAT returns {4'b0, overrun, tx_full, rx_avail, tx_busy}.
  - tx_busy = TX FIFO non-empty OR FSM not IDLE.
  - rx_avail = RX FIFO non-empty.
- ADDR_CTRL returns {4'b0, CTRL}.
- Any other address: r_data=0, hit=0.

TX FSM:
- IDLE: if tx_en=1 and the TX FIFO is non-empty, load tx_data from the head, pop, go to START.
- START: begin_flag=1 for exactly this cycle; go to WAIT_ACK.
- WAIT_ACK: wait for busy_flag=1, then go to WAIT_DONE.
- WAIT_DONE: wait for busy_flag=0, then go to IDLE.
- Latency: write to ADDR_DATA with FSM idle gives begin_flag 2 cycles later (push edge, load edge, pulse).
- tx_en cleared mid-byte: the current byte completes; no new byte is started.
- Push and pop in the same cycle: both take effect; count is unchanged.
- Full FIFO with a simultaneous pop: the push is accepted.

RX path:
- Rising edge of receive_flag (registered previous value) with rx_en=1 pushes rx_data, 1-cycle latency.
- RX FIFO full on push: the byte is dropped and overrun is set (sticky).
- Simultaneous push and pop when full: the push is accepted; no overrun.
- rx_en=0: edges are ignored and the edge register still tracks receive_flag.
- Overrun set and cleared in the same cycle: set wins.

Arithmetic:
- FIFO pointers are log2(DEPTH) bits with natural wrap.
- Count is log2(DEPTH)+1 bits.

Optional Feature:
UART_IRQ_EN.
- Defined:
  - Adds output irq (1 bit, registered, reset 0).
  - irq = (CTRL[2] & rx_avail) | (CTRL[3] & TX FIFO empty & FSM IDLE) | overrun.
  - Updates one cycle after its inputs change.
- Undefined:
  - No irq port.
  - CTRL[3:2] are still stored and read back, with no effect.

Test Plan:
- Reset mid-byte: rst_n low while FSM in WAIT_DONE -> immediately begin_flag=0, tx_en=0, STAT reads 8'h00, FIFOs empty.
- TX sequencing:
  - Stimulus: CTRL=8'h01, write 8'h41, 8'h42 to 253, UART model busy 10 cycles per byte.
  - Required: exactly two begin_flag pulses; tx_data=8'h41 then 8'h42; second pulse only after busy falls; STAT bit0 returns to 0 at end.
- TX full: CTRL=0, write 5 bytes with TX_DEPTH=4 -> STAT=8'h05 (tx_full and tx_busy set); enable tx -> only the first 4 bytes are transmitted.
- RX with overrun:
  - Stimulus: CTRL=8'h02, 5 receive_flag rising edges with bytes 8'h10..8'h14, no reads.
  - Required: STAT=8'h0A; reads return 8'h10..8'h13, then 0.
  - Then write 8'h08 to 254 -> STAT=8'h00.
- Simultaneous: RX FIFO full, receive edge in the same cycle as a load from 253 -> 8'h10 returned, new byte stored, overrun stays 0.
- UART_IRQ_EN build: CTRL=8'h06, receive one byte -> irq=1 within 2 cycles; read 253 -> irq=0 the next cycle.
